// File: rtl/seq_player_pkg.sv
// Shared types for the note sequencer: event layout, field widths and FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package seq_player_pkg;

    localparam int SEQ_DUR_W = 8;
    localparam int SEQ_CYC_W = 16;
    localparam int SEQ_EV_W  = SEQ_DUR_W + SEQ_CYC_W;

    // Event word: duration in tempo ticks in [23:16], oscillator half-period in [15:0].
    typedef struct packed {
        logic [SEQ_DUR_W-1:0] dur;
        logic [SEQ_CYC_W-1:0] cyc;
    } seq_ev_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_PLAY
    } seq_state_t;

    // A zero duration marks the end of the score; the pitch field is don't-care.
    function automatic logic seq_is_end(input seq_ev_t ev);
        return ev.dur == '0;
    endfunction

endpackage

// File: rtl/seq_mem.sv
// Event store: one write port, one synchronous read port; a same-address read
// returns the data held before the write (read-before-write).
// Latency: read data valid the cycle after rd_addr. Backpressure: none, writes always accepted.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr in, rd_data out (registered).
module seq_mem
    import seq_player_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = SEQ_EV_W
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    // Contents are deliberately not reset.
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/seq_player.sv
// Programmable note sequencer driving cyc/attack for the note oscillator and envelope.
// Latency: start -> FETCH -> DECODE -> note outputs; each note is dur*TICK_DIV clks plus 2 clks fetch overhead.
// Backpressure: none; start ignored while busy, stop aborts from any state and wins over start.
// Ports: clk, rst (async, active high); wr_en/wr_addr/wr_data load events;
//        start/stop/loop_en control; busy, attack, cyc, step_idx outputs.
module seq_player
    import seq_player_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int TICK_DIV   = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [SEQ_EV_W-1:0]   wr_data,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic                  busy,
    output logic                  attack,
    output logic [SEQ_CYC_W-1:0]  cyc,
    output logic [DEPTH_LOG2-1:0] step_idx
);

    localparam int                    DIV_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DEPTH_LOG2-1:0] ADDR_LAST = '1;

    seq_state_t            state, state_n;
    logic [DEPTH_LOG2-1:0] addr, addr_n;
    // Set when the address rolled over past the last entry; the next decode
    // treats it as an end marker regardless of what address 0 holds.
    logic                  wrap, wrap_n;
    logic [DIV_W-1:0]      div, div_n;
    logic [SEQ_DUR_W-1:0]  rem, rem_n;
    logic                  busy_n, attack_n;
    logic [SEQ_CYC_W-1:0]  cyc_n;
    logic [DEPTH_LOG2-1:0] step_n;

    logic [SEQ_EV_W-1:0]   rd_data;
    seq_ev_t               rd_ev;
    logic                  tick_wrap;

    seq_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (SEQ_EV_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (addr),
        .rd_data (rd_data)
    );

    assign rd_ev     = seq_ev_t'(rd_data);
    assign tick_wrap = (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            wrap     <= 1'b0;
            div      <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            attack   <= 1'b0;
            cyc      <= '0;
            step_idx <= '0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            wrap     <= wrap_n;
            div      <= div_n;
            rem      <= rem_n;
            busy     <= busy_n;
            attack   <= attack_n;
            cyc      <= cyc_n;
            step_idx <= step_n;
        end
    end

    always_comb begin
        state_n  = state;
        addr_n   = addr;
        wrap_n   = wrap;
        div_n    = div;
        rem_n    = rem;
        busy_n   = busy;
        attack_n = attack;
        cyc_n    = cyc;
        step_n   = step_idx;

        if (stop) begin
            state_n  = ST_IDLE;
            busy_n   = 1'b0;
            attack_n = 1'b0;
            cyc_n    = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_n = ST_FETCH;
                        addr_n  = '0;
                        wrap_n  = 1'b0;
                        div_n   = '0;
                        busy_n  = 1'b1;
                    end
                end

                // Memory read of addr is in flight; data lands for DECODE.
                ST_FETCH: begin
                    state_n = ST_DECODE;
                end

                ST_DECODE: begin
                    if (seq_is_end(rd_ev) || wrap) begin
                        if (loop_en) begin
                            state_n = ST_FETCH;
                            addr_n  = '0;
                            wrap_n  = 1'b0;
                        end else begin
                            state_n  = ST_IDLE;
                            busy_n   = 1'b0;
                            attack_n = 1'b0;
                            cyc_n    = '0;
                        end
                    end else begin
                        // Note parameters are latched here, so later writes to
                        // this address cannot disturb the note in progress.
                        state_n  = ST_PLAY;
                        cyc_n    = rd_ev.cyc;
                        step_n   = addr;
                        rem_n    = rd_ev.dur;
                        div_n    = '0;
                        attack_n = (rd_ev.cyc != '0);
                    end
                end

                ST_PLAY: begin
                    div_n = tick_wrap ? '0 : div + 1'b1;
                    if (tick_wrap) begin
                        attack_n = 1'b0;
                        rem_n    = rem - 1'b1;
                        if (rem == SEQ_DUR_W'(1)) begin
                            state_n = ST_FETCH;
                            addr_n  = addr + 1'b1;
                            if (addr == ADDR_LAST) begin
                                wrap_n = 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_player.sv
// Testbench for seq_player: randomized and directed scores, expected per-cycle
// output trace from a score-level model, compared by an independent monitor.
// Latency/backpressure: n/a (bench).
module tb_seq_player;

    localparam int DL    = 6;
    localparam int TD    = 4;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DL-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          busy;
    logic          attack;
    logic [15:0]   cyc;
    logic [DL-1:0] step_idx;

    always #5 clk = ~clk;

    seq_player #(
        .DEPTH_LOG2 (DL),
        .TICK_DIV   (TD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .stop     (stop),
        .loop_en  (loop_en),
        .busy     (busy),
        .attack   (attack),
        .cyc      (cyc),
        .step_idx (step_idx)
    );

    typedef struct {
        bit busy;
        bit attack;
        int cyc;
        int step;
    } obs_t;

    obs_t        q[$];
    obs_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          m_cyc = 0;
    int          m_step = 0;
    int          last_step = 0;
    logic [23:0] smem [DEPTH];

    // Monitor: one expected sample per clock while the scoreboard holds any.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            last_step = mon_e.step;
            checks++;
            if (busy !== mon_e.busy || attack !== mon_e.attack ||
                cyc !== mon_e.cyc[15:0] || step_idx !== mon_e.step[DL-1:0]) begin
                errors++;
                $display("FAIL trace @%0t: busy/attack/cyc/step got %0b/%0b/%0d/%0d expected %0b/%0b/%0d/%0d",
                         $time, busy, attack, cyc, step_idx,
                         mon_e.busy, mon_e.attack, mon_e.cyc, mon_e.step);
            end
        end
    end

    function automatic void push(input bit b, input bit a, input int c, input int s);
        q.push_back('{busy: b, attack: a, cyc: c, step: s});
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 0, m_step);
    endfunction

    function automatic logic [23:0] mk_ev(input int dur, input int c);
        return {dur[7:0], c[15:0]};
    endfunction

    // One pass through the score from address 0: every event (including the
    // end marker or the rollover past the last address) costs two cycles with
    // the previous outputs held, then a real event plays for dur*TD cycles.
    function automatic void gen_pass(input bit lp);
        int          a = 0;
        int          d;
        int          c;
        logic [23:0] ev;
        while (1) begin
            push(1'b1, 1'b0, m_cyc, m_step);
            push(1'b1, 1'b0, m_cyc, m_step);
            if (a == DEPTH) break;
            ev = smem[a];
            d  = int'(ev[23:16]);
            c  = int'(ev[15:0]);
            if (d == 0) break;
            for (int k = 0; k < d * TD; k++) push(1'b1, (k < TD) && (c != 0), c, a);
            m_cyc  = c;
            m_step = a;
            a++;
        end
        if (!lp) begin
            m_cyc = 0;
            push(1'b0, 1'b0, 0, m_step);
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic wr(input int a, input logic [23:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a[DL-1:0];
        wr_data = d;
        smem[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_play(input bit lp, input int passes);
        @(negedge clk);
        loop_en = lp;
        start   = 1'b1;
        for (int p = 0; p < passes; p++) gen_pass(lp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        q.delete();
        m_cyc  = 0;
        m_step = last_step;
        push_idle(3);
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL %s: timeout with %0d samples pending, expected 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic wait_q_below(input string nm, input int k, input int budget);
        int n = 0;
        while (q.size() >= k && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() >= k) begin
            errors++;
            $display("FAIL %s: queue still %0d after %0d clks, expected below %0d", nm, q.size(), n, k);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  d;
        int  c;
        bit  lp;
        bit  mid;

        for (int i = 0; i < DEPTH; i++) smem[i] = '0;

        // Reset state.
        #1;
        chk("reset_busy",   32'(busy),     32'd0);
        chk("reset_attack", 32'(attack),   32'd0);
        chk("reset_cyc",    32'(cyc),      32'd0);
        chk("reset_step",   32'(step_idx), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_idle(3);
        drain("idle_after_reset", 20);

        // Note, rest, end marker (its pitch field is ignored).
        wr(0, mk_ev(2, 100));
        wr(1, mk_ev(1, 0));
        wr(2, mk_ev(0, 1234));
        start_play(1'b0, 1);
        push_idle(3);
        drain("score_once", 200);

        // Same score looping; a start pulse while busy must be ignored.
        start_play(1'b1, 3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_q_below("loop_run", 6, 500);
        do_stop();
        drain("loop_stop", 50);

        // start and stop together: stop wins.
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        push_idle(3);
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        drain("start_stop_same", 20);

        // Rewrite the playing event mid-note; only the next pass sees it.
        wr(0, mk_ev(2, 200));
        wr(1, mk_ev(1, 50));
        wr(2, mk_ev(0, 0));
        start_play(1'b1, 1);
        @(negedge clk);
        wr(0, mk_ev(3, 500));
        gen_pass(1'b1);
        gen_pass(1'b1);
        wait_q_below("rewrite_run", 6, 500);
        do_stop();
        drain("rewrite_stop", 50);

        // Full memory, no end marker: playback ends at the address rollover.
        for (int k = 0; k < DEPTH; k++) wr(k, mk_ev(1, k + 1));
        start_play(1'b0, 1);
        push_idle(2);
        drain("full_wrap", 1000);

        // Asynchronous reset while attack is high.
        wr(0, mk_ev(2, 300));
        wr(1, mk_ev(0, 0));
        start_play(1'b0, 1);
        repeat (2) @(negedge clk);
        chk("attack_before_rst", 32'(attack), 32'd1);
        #2;
        rst = 1'b1;
        q.delete();
        #1;
        chk("rst_attack", 32'(attack),   32'd0);
        chk("rst_cyc",    32'(cyc),      32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_step",   32'(step_idx), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_cyc  = 0;
        m_step = 0;
        push_idle(5);
        drain("idle_after_rst", 20);

        // Randomized scores: loop or not, optional abort mid-score.
        for (int it = 0; it < 14; it++) begin
            n   = $urandom_range(1, 5);
            lp  = 1'($urandom_range(0, 1));
            mid = 1'($urandom_range(0, 1));
            for (int a = 0; a < n; a++) begin
                if (a == 0) d = $urandom_range(1, 3);
                else        d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3);
                c = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 65535);
                wr(a, mk_ev(d, c));
            end
            wr(n, mk_ev(0, $urandom_range(0, 65535)));
            if (lp) begin
                start_play(1'b1, 3);
            end else begin
                start_play(1'b0, 1);
                push_idle(2);
            end
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            if (lp) begin
                wait_q_below("rand_loop", 4, 2000);
                do_stop();
            end else if (mid) begin
                repeat ($urandom_range(1, 6)) @(negedge clk);
                do_stop();
            end
            drain("rand_score", 2000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_player.md
# seq_player

Programmable note sequencer that replaces the fixed score as the source of `cyc` (oscillator half-period) and `attack` for the note oscillator and envelope generator. A small event memory, loaded over a write port, holds pitch/duration events. Once started, the block steps through them on an internal tempo tick, raising `attack` once per note, and optionally loops. Its outputs feed `note` and `env` directly, so the PDM chain downstream is unchanged.

## Interface
- `DEPTH_LOG2`, 6: log2 of event memory depth (64 events).
- `TICK_DIV`, 65536: clk cycles per tempo tick; must be ≥ 2.
- `clk` in 1: system clock; same clock as `note` and `dsm`.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: event write strobe.
- `wr_addr` in DEPTH_LOG2: event write address.
- `wr_data` in 24: event; [23:16] duration in ticks, [15:0] cyc.
- `start` in 1: begin playback at address 0; level-sampled.
- `stop` in 1: abort playback; level-sampled.
- `loop_en` in 1: wrap to address 0 at the end of the score instead of stopping.
- `busy` out 1: playback in progress.
- `attack` out 1: note-on; held high for one full tick (`TICK_DIV` clks) so tick-rate consumers sample it.
- `cyc` out 16: current pitch half-period; 0 means silence.
- `step_idx` out DEPTH_LOG2: address of the event currently playing.

## Operation
- Reset: `busy`=0, `attack`=0, `cyc`=0, `step_idx`=0, FSM=IDLE, tick counter=0. Memory contents are not reset.
- Event decode:
  - dur=0 is the end-of-score marker; its cyc field is ignored.
  - cyc=0 with dur≠0 is a rest: `cyc` goes to 0, no `attack`, duration still counted.
- FSM states:
  - IDLE: `start`=1 and `stop`=0 → FETCH with address 0, tick counter cleared, `busy`=1.
  - FETCH: issue synchronous read for one cycle → DECODE.
  - DECODE:
    - End marker with `loop_en`=1 → FETCH at address 0.
    - End marker with `loop_en`=0 → IDLE, `cyc`=0, `busy`=0.
    - Otherwise → PLAY. Load `cyc` and `step_idx`, and load the remaining-tick counter with dur. Clear the tick divider. Set `attack` if cyc≠0.
  - PLAY:
    - The tick divider counts 0..TICK_DIV-1.
    - At the wrap: `attack` clears and remaining decrements.
    - When remaining reaches 0 at a wrap: address+1 → FETCH.
- Address wrap: after address 2^DEPTH_LOG2−1 the next address is 0. This is treated as an implicit end marker (obeys `loop_en`).
- `stop`=1 in any state: next cycle IDLE, `attack`=0, `cyc`=0, `busy`=0. `stop` wins over a simultaneous `start`.
- `start` while `busy`=1 is ignored.
- `loop_en` is sampled only at the end of the score.
- Writes are accepted in any state.
  - A write to the address being read in the same cycle returns the old data (read-before-write).
  - A write to the playing event does not affect the note in progress.

## Timing
- `start` sampled high at edge N → FETCH at N+1, DECODE at N+2. At edge N+3, `attack`/`cyc` are valid and `busy` is already high since N+1.
- A note lasts exactly dur×TICK_DIV clks in PLAY, plus 2 clks of FETCH/DECODE overhead before the next event's outputs update.
- `attack` high for exactly TICK_DIV clks starting at the cycle after DECODE.
- `cyc` changes only on leaving DECODE or on entering IDLE. It is stable throughout a note.
- Asynchronous reset mid-note: outputs go to 0 immediately. After release, the block stays IDLE until a new `start`.

## Structure
- In `def.v`:
  - `SEQ_DUR_W`=8 and `SEQ_CYC_W`=16.
  - Field macros `SEQ_DUR` [23:16] and `SEQ_CYC` [15:0].
  - FSM state encodings: IDLE, FETCH, DECODE, PLAY.
- Sub-module `seq_mem`: simple dual-port RAM (one write port, one synchronous read port, read-before-write), depth 2^DEPTH_LOG2 × 24.
- Top-level integration: `seq_player` replaces `score`. The `cyc`/`attack` wiring to `note` and `env` is unchanged.

## Test plan
- Load {dur=2,cyc=100}, {dur=1,cyc=0}, {dur=0}; TICK_DIV=4; `start` → `cyc`=100 for 8 clks with `attack` high for 4 clks. Then `cyc`=0 for 4 clks with no `attack`. Then IDLE with `busy`=0.
- Same score with `loop_en`=1 → `cyc` sequence 100, 0, 100 repeats; `attack` rises every 8+4+2+2+2 clks; `step_idx` returns to 0.
- Fill all 64 entries with dur=1,cyc=k+1, `loop_en`=0 → 64 notes, then stop at address wrap; `busy`=0, `cyc`=0.
- `start` and `stop` high in the same cycle → `busy` stays 0. `stop` mid-note → next cycle `cyc`=0, `attack`=0, `busy`=0.
- Write {dur=3,cyc=500} to `step_idx` while it plays {dur=2,cyc=200} → current note keeps 200 for 2 ticks. Next loop pass plays 500 for 3 ticks.
- Assert `rst` during `attack` → `attack`, `cyc`, `busy` are 0 before the next clk edge. After release, outputs stay 0 until `start`.
